pi_permute_stage: RTL and testbench

- Lane-permutation stage sitting directly downstream of the rho-rotation controller/datapath.
- Once the rotation stage has filled its 25-lane state memory, this block reads every lane back and writes it into a destination state memory.
- Mapping: A'[x][y] = A[(x+3y) mod 5][x], where lane address = 5*y + x.
- Runs under a start/done handshake with its own mod-5 counters and a small FSM.

---
 rtl/pi_permute_stage.sv | 109 ++++++++++
 tb/tb_pi_permute_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pi_permute_stage.sv
// rtl/pi_permute_stage.sv - pi lane permutation: copies A[(x+3y)%5][x] into A'[x][y] via read/write strobes
// Two-state-per-lane walk over destination lanes 0..24 with registered mod-5 counters.
module pi_permute_stage #(
   parameter int LANE_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [LANE_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [LANE_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   state_t     state, state_nxt;
   logic [2:0] dx, dy, sx;
   logic [2:0] dx_nxt, dy_nxt, sx_nxt;

   function automatic logic [ADDR_W-1:0] lane_addr(input logic [2:0] row, input logic [2:0] col);
      return ADDR_W'(row) * ADDR_W'(5) + ADDR_W'(col);
   endfunction

   // (3*dy) mod 5 for the first destination lane of each row
   function automatic logic [2:0] row_start(input logic [2:0] row);
      case (row)
         3'd1:    return 3'd3;
         3'd2:    return 3'd1;
         3'd3:    return 3'd4;
         3'd4:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         dx    <= 3'd0;
         dy    <= 3'd0;
         sx    <= 3'd0;
      end else begin
         state <= state_nxt;
         dx    <= dx_nxt;
         dy    <= dy_nxt;
         sx    <= sx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dx_nxt    = dx;
      dy_nxt    = dy;
      sx_nxt    = sx;
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RD;
               dx_nxt    = 3'd0;
               dy_nxt    = 3'd0;
               sx_nxt    = 3'd0;
            end
         end
         RD: begin
            rd_en     = 1'b1;
            rd_addr   = lane_addr(dx, sx);
            busy      = 1'b1;
            state_nxt = WR;
         end
         WR: begin
            wr_en   = 1'b1;
            wr_addr = lane_addr(dy, dx);
            wr_data = rd_data;
            busy    = 1'b1;
            if (dx == 3'd4 && dy == 3'd4) begin
               state_nxt = FIN;
            end else begin
               state_nxt = RD;
               if (dx != 3'd4) begin
                  dx_nxt = dx + 3'd1;
                  sx_nxt = (sx == 3'd4) ? 3'd0 : sx + 3'd1;
               end else begin
                  dx_nxt = 3'd0;
                  dy_nxt = dy + 3'd1;
                  sx_nxt = row_start(dy + 3'd1);
               end
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pi_permute_stage.sv
// tb/tb_pi_permute_stage.sv - self-checking bench for pi_permute_stage against an arithmetic pi model
module tb_pi_permute_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [63:0] rd_data = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [63:0] src_mem [25];
   logic [4:0]  wa_q [$];
   logic [63:0] wd_q [$];
   logic [4:0]  ra_q [$];
   int          done_q [$];

   pi_permute_stage #(.LANE_W(64), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

   // Destination lane a=(x,y) comes from source lane x'=(x+3y)%5, y'=x
   function automatic int src_of(input int a);
      int x, y;
      x = a % 5;
      y = a / 5;
      return 5 * x + (x + 3 * y) % 5;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rd_en"},   64'(rd_en),   64'd0);
      check({tag, "_wr_en"},   64'(wr_en),   64'd0);
      check({tag, "_busy"},    64'(busy),    64'd0);
      check({tag, "_done"},    64'(done),    64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, wr_data,      64'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 25; i++) src_mem[i] = {$urandom, $urandom};
   endtask

   // launched: start already sampled at the previous edge; chain: pulse start in the cycle after done
   task automatic run(input bit launched, input bit chain, input int busy_start_cyc, input int rst_cyc);
      int n;
      if (!launched) begin
         @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      wa_q.delete(); wd_q.delete(); ra_q.delete(); done_q.delete();
      for (int cyc = 1; cyc <= 51; cyc++) begin
         @(negedge clk);
         start = (cyc == busy_start_cyc);
         if (cyc == rst_cyc) begin
            start = 1'b0;
            rst = 1'b0;
            #1 check_quiet("midrst");
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               check("midrst_hold_wr_en", 64'(wr_en), 64'd0);
               check("midrst_hold_done",  64'(done),  64'd0);
            end
            rst = 1'b1;
            return;
         end
         check("excl_rd_wr", 64'(rd_en & wr_en), 64'd0);
         check("busy_window", 64'(busy), 64'(cyc <= 50));
         if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
         if (rd_en) ra_q.push_back(rd_addr);
         if (done) done_q.push_back(cyc);
      end
      @(negedge clk);
      check("post_busy",  64'(busy),  64'd0);
      check("post_done",  64'(done),  64'd0);
      check("post_wr_en", 64'(wr_en), 64'd0);
      start = chain;
      @(posedge clk);
      #1 start = 1'b0;

      check("write_count", 64'(wa_q.size()), 64'd25);
      check("read_count",  64'(ra_q.size()), 64'd25);
      n = (wa_q.size() < 25) ? wa_q.size() : 25;
      for (int k = 0; k < n; k++) begin
         check($sformatf("wr_addr[%0d]", k), 64'(wa_q[k]), 64'(k));
         check($sformatf("wr_data[%0d]", k), wd_q[k], src_mem[src_of(k)]);
      end
      n = (ra_q.size() < 25) ? ra_q.size() : 25;
      for (int k = 0; k < n; k++)
         check($sformatf("rd_addr[%0d]", k), 64'(ra_q[k]), 64'(src_of(k)));
      check("done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() > 0) check("done_cycle", 64'(done_q[0]), 64'd51);
   endtask

   initial begin
      int first_reads [6];
      first_reads = '{0, 6, 12, 18, 24, 3};

      // Reset held with start asserted: nothing may move
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_quiet($sformatf("reset%0d", k));
      end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_quiet("post_reset_idle");

      // Identity preload: lane i holds i
      for (int i = 0; i < 25; i++) src_mem[i] = 64'(i);
      run(1'b0, 1'b0, -1, -1);
      for (int k = 0; k < 6 && k < ra_q.size(); k++)
         check($sformatf("first_read[%0d]", k), 64'(ra_q[k]), 64'(first_reads[k]));
      if (wd_q.size() == 25) begin
         check("ident_wr0",  wd_q[0],  64'd0);
         check("ident_wr1",  wd_q[1],  64'd6);
         check("ident_wr2",  wd_q[2],  64'd12);
         check("ident_wr5",  wd_q[5],  64'd3);
         check("ident_wr17", wd_q[17], 64'd11);
         check("ident_wr24", wd_q[24], 64'd21);
      end else begin
         check("ident_size", 64'(wd_q.size()), 64'd25);
      end

      // Start while busy, then back-to-back chained run
      fill_random();
      run(1'b0, 1'b1, 10, -1);
      run(1'b1, 1'b0, -1, -1);

      // Mid-run reset, then a clean restart from lane 0
      fill_random();
      run(1'b0, 1'b0, -1, 20);
      @(negedge clk);
      check_quiet("after_midrst");
      fill_random();
      run(1'b0, 1'b0, -1, -1);

      for (int r = 0; r < 3; r++) begin
         fill_random();
         run(1'b0, 1'b0, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
